// File: rtl/bus4to1_rr.sv
// Four-master to one-slave round-robin arbiter for the valid/ready memory bus.
// Latency: request to s_valid is one cycle (arbitrate in IDLE, forward in GRANT); one IDLE cycle between grants.
// Backpressure: the granted master waits on s_ready; losers hold valid and are served within three transactions.
//
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   mN_valid/ready/addr/rdata/wdata/wstrb (N=0..3)  master side; wstrb==0 means read
//   s_valid/ready/addr/rdata/wdata/wstrb            slave side; s_ready is a completion pulse
//   bus_err                     one-cycle pulse when the watchdog ends a transaction
//   err_id                      master index of the most recent watchdog expiry
module bus4to1_rr #(
    parameter int unsigned TIMEOUT       = 0,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    output logic [31:0] m0_rdata,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,

    input  logic        m2_valid,
    output logic        m2_ready,
    input  logic [31:0] m2_addr,
    output logic [31:0] m2_rdata,
    input  logic [31:0] m2_wdata,
    input  logic [3:0]  m2_wstrb,

    input  logic        m3_valid,
    output logic        m3_ready,
    input  logic [31:0] m3_addr,
    output logic [31:0] m3_rdata,
    input  logic [31:0] m3_wdata,
    input  logic [3:0]  m3_wstrb,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    input  logic [31:0] s_rdata,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,

    output logic        bus_err,
    output logic [1:0]  err_id
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [31:0] r_wdog;
    logic [31:0] w_wdog_nxt;
    logic [1:0]  r_err_id;
    logic [1:0]  w_err_id_nxt;

    // Master buses gathered into arrays so the grant index can select them.
    logic [3:0]  w_m_valid;
    logic [3:0]  w_m_ready;
    logic [31:0] w_m_addr  [4];
    logic [31:0] w_m_wdata [4];
    logic [3:0]  w_m_wstrb [4];
    logic [31:0] w_m_rdata [4];

    assign w_m_valid    = {m3_valid, m2_valid, m1_valid, m0_valid};
    assign w_m_addr[0]  = m0_addr;
    assign w_m_addr[1]  = m1_addr;
    assign w_m_addr[2]  = m2_addr;
    assign w_m_addr[3]  = m3_addr;
    assign w_m_wdata[0] = m0_wdata;
    assign w_m_wdata[1] = m1_wdata;
    assign w_m_wdata[2] = m2_wdata;
    assign w_m_wdata[3] = m3_wdata;
    assign w_m_wstrb[0] = m0_wstrb;
    assign w_m_wstrb[1] = m1_wstrb;
    assign w_m_wstrb[2] = m2_wstrb;
    assign w_m_wstrb[3] = m3_wstrb;

    assign m0_ready = w_m_ready[0];
    assign m1_ready = w_m_ready[1];
    assign m2_ready = w_m_ready[2];
    assign m3_ready = w_m_ready[3];
    assign m0_rdata = w_m_rdata[0];
    assign m1_rdata = w_m_rdata[1];
    assign m2_rdata = w_m_rdata[2];
    assign m3_rdata = w_m_rdata[3];

    assign err_id = r_err_id;

    logic w_g_valid;
    assign w_g_valid = w_m_valid[r_grant];

    // Round-robin pick: scan last+1, last+2, ... with 2-bit wraparound.
    logic       w_arb_vld;
    logic [1:0] w_arb_idx;
    logic [1:0] w_cand;

    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = r_last;
        w_cand    = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_arb_vld && w_m_valid[w_cand]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = w_cand;
            end
        end
    end

    // Expiry needs a live request; s_ready in the same cycle takes precedence.
    logic w_expire;

    if (TIMEOUT > 0) begin : g_wdog
        assign w_expire = (r_state == ST_GRANT) && (r_wdog == 32'(TIMEOUT - 1))
                          && !s_ready && w_g_valid;
    end else begin : g_no_wdog
        assign w_expire = 1'b0;
    end

    assign bus_err = w_expire;

    // Output muxing: everything is zero outside GRANT and for non-granted masters.
    always_comb begin
        s_valid   = 1'b0;
        s_addr    = 32'h0;
        s_wdata   = 32'h0;
        s_wstrb   = 4'h0;
        w_m_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_m_rdata[i] = 32'h0;
        end
        if (r_state == ST_GRANT) begin
            s_valid = w_g_valid && !w_expire;
            s_addr  = w_m_addr[r_grant];
            s_wdata = w_m_wdata[r_grant];
            s_wstrb = w_m_wstrb[r_grant];
            for (int i = 0; i < 4; i++) begin
                if (r_grant == 2'(i)) begin
                    // A dropped valid (abort) never gets a ready, even with s_ready high.
                    w_m_ready[i] = w_g_valid && (s_ready || w_expire);
                    w_m_rdata[i] = w_expire ? TIMEOUT_RDATA : s_rdata;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_last_nxt   = r_last;
        w_wdog_nxt   = r_wdog;
        w_err_id_nxt = r_err_id;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_arb_idx;
                    w_wdog_nxt  = 32'h0;
                end
            end
            ST_GRANT: begin
                if (!w_g_valid) begin
                    // Abort: leave priority untouched so the same rotation resumes.
                    w_state_nxt = ST_IDLE;
                end else if (s_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_grant;
                end else if (w_expire) begin
                    w_state_nxt  = ST_IDLE;
                    w_last_nxt   = r_grant;
                    w_err_id_nxt = r_grant;
                end else if (r_wdog != 32'hFFFF_FFFF) begin
                    w_wdog_nxt = r_wdog + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'd0;
            r_last   <= 2'd3;
            r_wdog   <= 32'h0;
            r_err_id <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_last   <= w_last_nxt;
            r_wdog   <= w_wdog_nxt;
            r_err_id <= w_err_id_nxt;
        end
    end

endmodule

// File: tb/tb_bus4to1_rr.sv
module tb_bus4to1_rr;

    localparam int          TO  = 4;
    localparam logic [31:0] TRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [3:0]  v;
    logic [31:0] a  [4];
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, m2_ready, m3_ready;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata, m3_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        bus_err;
    logic [1:0]  err_id;

    logic [31:0] rd [4];
    assign rd[0] = m0_rdata;
    assign rd[1] = m1_rdata;
    assign rd[2] = m2_rdata;
    assign rd[3] = m3_rdata;

    bus4to1_rr #(.TIMEOUT(TO), .TIMEOUT_RDATA(TRD)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(v[0]), .m0_ready(m0_ready), .m0_addr(a[0]), .m0_rdata(m0_rdata), .m0_wdata(wd[0]), .m0_wstrb(ws[0]),
        .m1_valid(v[1]), .m1_ready(m1_ready), .m1_addr(a[1]), .m1_rdata(m1_rdata), .m1_wdata(wd[1]), .m1_wstrb(ws[1]),
        .m2_valid(v[2]), .m2_ready(m2_ready), .m2_addr(a[2]), .m2_rdata(m2_rdata), .m2_wdata(wd[2]), .m2_wstrb(ws[2]),
        .m3_valid(v[3]), .m3_ready(m3_ready), .m3_addr(a[3]), .m3_rdata(m3_rdata), .m3_wdata(wd[3]), .m3_wstrb(ws[3]),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_rdata(s_rdata),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .bus_err(bus_err), .err_id(err_id)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One table row = one clock cycle: inputs, then the outputs expected in that cycle.
    // g is the master the slave bus should be muxed to (4 = nothing, bus idle).
    typedef struct {
        bit        rstn;
        bit [3:0]  v;
        bit        sr;
        bit [31:0] rd;
        bit        svld;
        bit [3:0]  rdy;
        int        g;
        bit        berr;
        bit [1:0]  eid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rstn, bit [3:0] vv, bit sr, bit [31:0] rdv, bit svld,
                                bit [3:0] rdy, int g, bit berr, bit [1:0] eid);
        vec_t x;
        x.rstn = rstn; x.v = vv; x.sr = sr; x.rd = rdv; x.svld = svld;
        x.rdy = rdy; x.g = g; x.berr = berr; x.eid = eid;
        return x;
    endfunction

    function automatic logic [31:0] addr_of(int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [3:0] wstrb_of(int i);
        logic [3:0] t [4];
        t[0] = 4'h0; t[1] = 4'hF; t[2] = 4'h0; t[3] = 4'h3;
        return t[i];
    endfunction

    task automatic apply(input vec_t x, input string tag);
        logic [31:0] e_rd;
        @(negedge clk);
        resetn  = x.rstn;
        v       = x.v;
        s_ready = x.sr;
        s_rdata = x.rd;
        #1;
        n_vec++;
        chk({tag, ".s_valid"}, 32'(s_valid), 32'(x.svld));
        chk({tag, ".ready"}, 32'({m3_ready, m2_ready, m1_ready, m0_ready}), 32'(x.rdy));
        chk({tag, ".s_addr"}, s_addr, (x.g < 4) ? addr_of(x.g) : 32'h0);
        chk({tag, ".s_wstrb"}, 32'(s_wstrb), (x.g < 4) ? 32'(wstrb_of(x.g)) : 32'h0);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(x.berr));
        chk({tag, ".err_id"}, 32'(err_id), 32'(x.eid));
        for (int i = 0; i < 4; i++) begin
            e_rd = (i == x.g) ? (x.berr ? TRD : x.rd) : 32'h0;
            chk($sformatf("%s.rdata%0d", tag, i), rd[i], e_rd);
        end
    endtask

    // Random-phase reference model state
    bit          busy;
    int          own, last, wt;
    bit [1:0]    eid;
    int          scnt [4];
    bit [3:0]    drop;
    bit          e_svld, e_berr, expd, gv;
    bit [3:0]    e_rdy;
    logic [31:0] e_addr, e_wd, e_rdv [4];
    logic [3:0]  e_ws;

    initial begin
        resetn = 1'b0; v = 4'h0; s_ready = 1'b0; s_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a[i] = addr_of(i); wd[i] = 32'hD000_0000 + 32'(i); ws[i] = wstrb_of(i);
        end
        repeat (2) @(posedge clk);

        // m2 read, slave acks on the 4th GRANT cycle (also the watchdog-limit cycle)
        tbl.push_back(mk(1, 4'b0100, 0, 0,             0, 4'b0000, 4, 0, 0));
        repeat (3) tbl.push_back(mk(1, 4'b0100, 0, 0,  1, 4'b0000, 2, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 1, 32'h1234_5678, 1, 4'b0100, 2, 0, 0));
        // reset, then all four continuously valid with immediate acks: 0,1,2,3,0
        tbl.push_back(mk(0, 4'b0000, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 32'h0000_0A00, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 32'h0000_0A01, 1, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 32'h0000_0A02, 1, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 32'h0000_0A03, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 32'h0000_0A04, 1, 4'b0001, 0, 0, 0));
        // serve m1 so last=1, then m0+m3 together: m3 wins
        tbl.push_back(mk(1, 4'b0010, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 32'h0000_0B01, 1, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1001, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1001, 1, 32'h0000_0B03, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 1, 32'h0000_0B00, 1, 4'b0001, 0, 0, 0));
        // m1 write, slave silent: expiry on the 4th GRANT cycle
        tbl.push_back(mk(1, 4'b0010, 0, 0,             0, 4'b0000, 4, 0, 0));
        repeat (3) tbl.push_back(mk(1, 4'b0010, 0, 0,  1, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 0, 32'h5555_5555, 0, 4'b0010, 1, 1, 0));
        // m1 again: s_ready lands exactly on the expiry cycle and wins
        tbl.push_back(mk(1, 4'b0010, 0, 0,             0, 4'b0000, 4, 0, 1));
        repeat (3) tbl.push_back(mk(1, 4'b0010, 0, 0,  1, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 1, 32'hCAFE_F00D, 1, 4'b0010, 1, 0, 1));
        // reset while m3 waits: no ready for m3, m0 first afterwards
        tbl.push_back(mk(1, 4'b1000, 0, 0,             0, 4'b0000, 4, 0, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 0,             1, 4'b0000, 3, 0, 1));
        tbl.push_back(mk(0, 4'b1001, 0, 0,             1, 4'b0000, 3, 0, 1));
        tbl.push_back(mk(1, 4'b1001, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1001, 1, 32'h0000_0E00, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 0,             0, 4'b0000, 4, 0, 0));
        tbl.push_back(mk(1, 4'b1000, 1, 32'h0000_0E03, 1, 4'b1000, 3, 0, 0));

        for (int r = 0; r < tbl.size(); r++) apply(tbl[r], $sformatf("row%0d", r));

        // Abort: m2 drops valid while s_ready is high -> no ready, last stays 3,
        // so m2 (not m3) wins the next m2+m3 arbitration.
        apply(mk(1, 4'b0100, 0, 0,             0, 4'b0000, 4, 0, 0), "abort_a");
        apply(mk(1, 4'b0000, 1, 32'h7777_7777, 0, 4'b0000, 2, 0, 0), "abort_b");
        apply(mk(1, 4'b1100, 0, 0,             0, 4'b0000, 4, 0, 0), "abort_c");
        apply(mk(1, 4'b1100, 1, 32'h2222_2222, 1, 4'b0100, 2, 0, 0), "abort_d");
        apply(mk(1, 4'b1000, 0, 0,             0, 4'b0000, 4, 0, 0), "abort_e");
        apply(mk(1, 4'b1000, 1, 32'h3333_3333, 1, 4'b1000, 3, 0, 0), "abort_f");

        // Randomized traffic against the reference model
        @(negedge clk);
        resetn = 1'b0; v = 4'h0; s_ready = 1'b0;
        @(posedge clk);
        busy = 0; own = 0; last = 3; wt = 0; eid = 0; drop = 4'h0;
        for (int i = 0; i < 4; i++) scnt[i] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (drop[i]) begin v[i] = 1'b0; scnt[i] = 0; end
                if (!v[i]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        v[i] = 1'b1; a[i] = $urandom; wd[i] = $urandom;
                        ws[i] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    v[i] = 1'b0; scnt[i] = 0;
                end
            end
            s_ready = ($urandom_range(0, 9) < 3);
            s_rdata = $urandom;
            resetn  = ($urandom_range(0, 199) != 0);
            #1;

            e_svld = 0; e_berr = 0; e_rdy = 4'h0; e_addr = 0; e_wd = 0; e_ws = 0; expd = 0; gv = 0;
            for (int i = 0; i < 4; i++) e_rdv[i] = 32'h0;
            if (busy) begin
                gv         = v[own];
                expd       = (wt == TO - 1) && !s_ready && gv;
                e_svld     = gv && !expd;
                e_addr     = a[own];
                e_wd       = wd[own];
                e_ws       = ws[own];
                e_rdy[own] = gv && (s_ready || expd);
                e_rdv[own] = expd ? TRD : s_rdata;
                e_berr     = expd;
            end

            n_vec++;
            chk($sformatf("rnd%0d.s_valid", cyc), 32'(s_valid), 32'(e_svld));
            chk($sformatf("rnd%0d.ready", cyc), 32'({m3_ready, m2_ready, m1_ready, m0_ready}), 32'(e_rdy));
            chk($sformatf("rnd%0d.s_addr", cyc), s_addr, e_addr);
            chk($sformatf("rnd%0d.s_wdata", cyc), s_wdata, e_wd);
            chk($sformatf("rnd%0d.s_wstrb", cyc), 32'(s_wstrb), 32'(e_ws));
            chk($sformatf("rnd%0d.bus_err", cyc), 32'(bus_err), 32'(e_berr));
            chk($sformatf("rnd%0d.err_id", cyc), 32'(err_id), 32'(eid));
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d.rdata%0d", cyc, i), rd[i], e_rdv[i]);

            drop = e_rdy;
            if (!resetn) begin
                busy = 0; last = 3; eid = 0;
                for (int i = 0; i < 4; i++) scnt[i] = 0;
            end else if (!busy) begin
                for (int k = 1; k <= 4; k++) begin
                    if (v[(last + k) % 4]) begin
                        busy = 1; own = (last + k) % 4; wt = 0;
                        break;
                    end
                end
            end else if (!gv) begin
                busy = 0;
            end else if (s_ready || expd) begin
                busy = 0; last = own;
                if (expd) eid = 2'(own);
                scnt[own] = 0;
                for (int i = 0; i < 4; i++) begin
                    if (i != own && v[i]) begin
                        scnt[i]++;
                        chk($sformatf("rnd%0d.starve%0d", cyc, i), 32'(scnt[i] > 3), 32'h0);
                    end
                end
            end else begin
                wt++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
